// File: rtl/multicycle_fsm.sv
// Multicycle RV32I control FSM: FETCH/DECODE/EXEC/MEM/WB/TRAP with outputs decoded
// combinationally from the registered state and the live instruction fields and flags.
module multicycle_fsm (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       zero,
  input  logic       lt,
  input  logic       ltu,
  input  logic       mem_ready,
  output logic       pc_we,
  output logic       ir_we,
  output logic       regwrite,
  output logic       mem_req,
  output logic       mem_we,
  output logic       iord,
  output logic [1:0] pc_src,
  output logic [1:0] wb_sel,
  output logic [1:0] alusrc_a,
  output logic       alusrc_b,
  output logic [3:0] aluctl,
  output logic [2:0] state,
  output logic       retire,
  output logic       illegal
);
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd7
  } state_t;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LD    = 7'b0000011;
  localparam logic [6:0] OP_ST    = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  state_t r_state, w_next;

  logic w_is_r, w_is_i, w_is_ld, w_is_st, w_is_br;
  logic w_is_jal, w_is_jalr, w_is_lui, w_is_auipc;
  logic w_legal, w_taken;
  logic [3:0] w_alu_ctl;

  assign w_is_r     = (opcode == OP_R);
  assign w_is_i     = (opcode == OP_I);
  assign w_is_ld    = (opcode == OP_LD);
  assign w_is_st    = (opcode == OP_ST);
  assign w_is_br    = (opcode == OP_BR);
  assign w_is_jal   = (opcode == OP_JAL);
  assign w_is_jalr  = (opcode == OP_JALR);
  assign w_is_lui   = (opcode == OP_LUI);
  assign w_is_auipc = (opcode == OP_AUIPC);

  // Branch funct3 010/011 has no defined comparison, so it traps like an unknown opcode.
  assign w_legal = (w_is_r | w_is_i | w_is_ld | w_is_st | w_is_jal | w_is_jalr |
                    w_is_lui | w_is_auipc | (w_is_br & (funct3[2:1] != 2'b01)));

  always_comb begin
    w_taken = 1'b0;
    case (funct3)
      3'b000:  w_taken = zero;
      3'b001:  w_taken = ~zero;
      3'b100:  w_taken = lt;
      3'b101:  w_taken = ~lt;
      3'b110:  w_taken = ltu;
      3'b111:  w_taken = ~ltu;
      default: w_taken = 1'b0;
    endcase
  end

  // funct7_5 only means SUB for R-type; for I-type it is immediate bits except on shifts.
  always_comb begin
    w_alu_ctl = 4'b0000;
    case (funct3)
      3'b000:  w_alu_ctl = (w_is_r && funct7_5) ? 4'b0110 : 4'b0010;
      3'b001:  w_alu_ctl = 4'b0100;
      3'b010:  w_alu_ctl = 4'b0111;
      3'b011:  w_alu_ctl = 4'b1001;
      3'b100:  w_alu_ctl = 4'b0011;
      3'b101:  w_alu_ctl = funct7_5 ? 4'b1000 : 4'b0101;
      3'b110:  w_alu_ctl = 4'b0001;
      default: w_alu_ctl = 4'b0000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_FETCH;
    else        r_state <= w_next;
  end

  assign state = r_state;

  always_comb begin
    w_next   = r_state;
    pc_we    = 1'b0;
    ir_we    = 1'b0;
    regwrite = 1'b0;
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    iord     = 1'b0;
    pc_src   = 2'b00;
    wb_sel   = 2'b00;
    alusrc_a = 2'b00;
    alusrc_b = 1'b0;
    aluctl   = 4'b0000;
    retire   = 1'b0;
    illegal  = 1'b0;
    case (r_state)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_we  = 1'b1;
          pc_we  = 1'b1;
          w_next = S_DECODE;
        end
      end
      S_DECODE: w_next = w_legal ? S_EXEC : S_TRAP;
      S_EXEC: begin
        w_next = S_WB;
        if (w_is_br) begin
          aluctl = 4'b0110;
          retire = 1'b1;
          w_next = S_FETCH;
          if (w_taken) begin
            pc_we  = 1'b1;
            pc_src = 2'b01;
          end
        end else if (w_is_jal || w_is_jalr) begin
          pc_we    = 1'b1;
          pc_src   = w_is_jalr ? 2'b10 : 2'b01;
          alusrc_a = w_is_jal ? 2'b01 : 2'b00;
          alusrc_b = 1'b1;
          aluctl   = 4'b0010;
        end else if (w_is_ld || w_is_st) begin
          alusrc_b = 1'b1;
          aluctl   = 4'b0010;
          w_next   = S_MEM;
        end else if (w_is_lui || w_is_auipc) begin
          alusrc_a = w_is_lui ? 2'b10 : 2'b01;
          alusrc_b = 1'b1;
          aluctl   = 4'b0010;
        end else if (w_is_r || w_is_i) begin
          alusrc_b = w_is_i;
          aluctl   = w_alu_ctl;
        end else begin
          w_next = S_TRAP;
        end
      end
      S_MEM: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        mem_we  = w_is_st;
        if (mem_ready) begin
          retire = w_is_st;
          w_next = w_is_st ? S_FETCH : S_WB;
        end
      end
      S_WB: begin
        regwrite = 1'b1;
        retire   = 1'b1;
        wb_sel   = w_is_ld ? 2'b01 : ((w_is_jal || w_is_jalr) ? 2'b10 : 2'b00);
        w_next   = S_FETCH;
      end
      S_TRAP: begin
        illegal = 1'b1;
        w_next  = S_TRAP;
      end
      default: w_next = S_FETCH;
    endcase
  end
endmodule

// File: tb/tb_multicycle_fsm.sv
// Directed bench for multicycle_fsm: per-cycle stimulus/expected tables, checked at posedge+2.
module tb_multicycle_fsm;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_5, zero, lt, ltu, mem_ready;
  logic       pc_we, ir_we, regwrite, mem_req, mem_we, iord, alusrc_b, retire, illegal;
  logic [1:0] pc_src, wb_sel, alusrc_a;
  logic [3:0] aluctl;
  logic [2:0] state;

  always #5 clk = ~clk;

  multicycle_fsm dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
    .zero(zero), .lt(lt), .ltu(ltu), .mem_ready(mem_ready),
    .pc_we(pc_we), .ir_we(ir_we), .regwrite(regwrite), .mem_req(mem_req), .mem_we(mem_we),
    .iord(iord), .pc_src(pc_src), .wb_sel(wb_sel), .alusrc_a(alusrc_a), .alusrc_b(alusrc_b),
    .aluctl(aluctl), .state(state), .retire(retire), .illegal(illegal)
  );

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LD    = 7'b0000011;
  localparam logic [6:0] OP_ST    = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  typedef struct packed {
    logic pc_we, ir_we, regwrite, mem_req, mem_we, iord;
    logic [1:0] pc_src, wb_sel, asa;
    logic asb;
    logic [3:0] aluctl;
    logic [2:0] state;
    logic retire, illegal;
  } ov_t;

  typedef struct packed {
    logic [6:0] op;
    logic [2:0] f3;
    logic f7, z, lt, ltu, rdy, rst;
  } stim_t;

  ov_t obs;
  assign obs = {pc_we, ir_we, regwrite, mem_req, mem_we, iord, pc_src, wb_sel,
                alusrc_a, alusrc_b, aluctl, state, retire, illegal};

  stim_t sq[$];
  ov_t   eq[$];
  int    total = 0;
  int    bad   = 0;

  function automatic stim_t mk(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                               input logic rdy);
    stim_t s;
    s = '0; s.op = op; s.f3 = f3; s.f7 = f7; s.rdy = rdy; s.rst = 1'b1;
    return s;
  endfunction

  function automatic ov_t fetch(input logic rdy);
    ov_t e;
    e = '0; e.mem_req = 1'b1; e.ir_we = rdy; e.pc_we = rdy;
    return e;
  endfunction

  function automatic ov_t dec();
    ov_t e;
    e = '0; e.state = 3'd1;
    return e;
  endfunction

  function automatic ov_t exu(input logic [3:0] ctl, input logic [1:0] a, input logic b);
    ov_t e;
    e = '0; e.state = 3'd2; e.aluctl = ctl; e.asa = a; e.asb = b;
    return e;
  endfunction

  function automatic ov_t memc(input logic we);
    ov_t e;
    e = '0; e.state = 3'd3; e.mem_req = 1'b1; e.iord = 1'b1; e.mem_we = we;
    return e;
  endfunction

  function automatic ov_t wb(input logic [1:0] sel);
    ov_t e;
    e = '0; e.state = 3'd4; e.regwrite = 1'b1; e.retire = 1'b1; e.wb_sel = sel;
    return e;
  endfunction

  function automatic ov_t trap();
    ov_t e;
    e = '0; e.state = 3'd7; e.illegal = 1'b1;
    return e;
  endfunction

  task automatic apply(input stim_t s);
    opcode = s.op; funct3 = s.f3; funct7_5 = s.f7;
    zero = s.z; lt = s.lt; ltu = s.ltu; mem_ready = s.rdy; rst_n = s.rst;
  endtask

  task automatic push(input stim_t s, input ov_t e);
    sq.push_back(s);
    eq.push_back(e);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; mem_ready = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    sq.delete(); eq.delete();
  endtask

  task automatic test_reset();
    opcode = OP_JAL; funct3 = 3'b000; funct7_5 = 1'b1; zero = 1'b1; lt = 1'b1; ltu = 1'b1;
    mem_ready = 1'b0; rst_n = 1'b0;
    @(posedge clk); #2;
    total++;
    if (obs !== fetch(1'b0)) begin
      bad++; $display("FAIL reset got=%h exp=%h", obs, fetch(1'b0));
    end
    rst_n = 1'b1;
  endtask

  task automatic test_add();
    stim_t s;
    do_reset();
    s = mk(OP_R, 3'b000, 1'b0, 1'b1);
    push(s, fetch(1'b1)); push(s, dec()); push(s, exu(4'b0010, 2'b00, 1'b0)); push(s, wb(2'b00));
    s.rdy = 1'b0; push(s, fetch(1'b0));
    for (int i = 0; i < sq.size(); i++) begin
      apply(sq[i]); #1; total++;
      if (obs !== eq[i]) begin bad++; $display("FAIL add cyc%0d got=%h exp=%h", i, obs, eq[i]); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch();
    // {funct3, zero, lt, ltu, taken}
    logic [6:0] bt [0:9];
    stim_t s;
    ov_t e;
    bt = '{7'b001_1_0_0_0, 7'b001_0_0_0_1, 7'b000_1_0_0_1, 7'b000_0_1_1_0, 7'b100_0_1_0_1,
           7'b101_0_1_0_0, 7'b101_0_0_1_1, 7'b110_0_0_1_1, 7'b111_0_0_1_0, 7'b111_1_1_0_1};
    do_reset();
    for (int k = 0; k < 10; k++) begin
      s = mk(OP_BR, bt[k][6:4], 1'b0, 1'b1);
      s.z = bt[k][3]; s.lt = bt[k][2]; s.ltu = bt[k][1];
      push(s, fetch(1'b1)); push(s, dec());
      e = exu(4'b0110, 2'b00, 1'b0); e.retire = 1'b1;
      e.pc_we = bt[k][0]; e.pc_src = bt[k][0] ? 2'b01 : 2'b00;
      push(s, e);
    end
    s.rdy = 1'b0; push(s, fetch(1'b0));
    for (int i = 0; i < sq.size(); i++) begin
      apply(sq[i]); #1; total++;
      if (obs !== eq[i]) begin bad++; $display("FAIL branch cyc%0d got=%h exp=%h", i, obs, eq[i]); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_load();
    stim_t s;
    do_reset();
    s = mk(OP_LD, 3'b010, 1'b0, 1'b1);
    push(s, fetch(1'b1)); push(s, dec()); push(s, exu(4'b0010, 2'b00, 1'b1));
    s.rdy = 1'b0;
    for (int k = 0; k < 3; k++) push(s, memc(1'b0));
    s.rdy = 1'b1; push(s, memc(1'b0)); push(s, wb(2'b01));
    // second load aborted by reset while in WB
    push(s, fetch(1'b1)); push(s, dec()); push(s, exu(4'b0010, 2'b00, 1'b1)); push(s, memc(1'b0));
    s.rst = 1'b0; push(s, wb(2'b01));
    s.rst = 1'b1; s.rdy = 1'b0; push(s, fetch(1'b0));
    for (int i = 0; i < sq.size(); i++) begin
      apply(sq[i]); #1; total++;
      if (obs !== eq[i]) begin bad++; $display("FAIL load cyc%0d got=%h exp=%h", i, obs, eq[i]); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_store();
    stim_t s;
    ov_t e;
    do_reset();
    s = mk(OP_ST, 3'b010, 1'b0, 1'b0);
    push(s, fetch(1'b0));
    s.rdy = 1'b1; push(s, fetch(1'b1)); push(s, dec()); push(s, exu(4'b0010, 2'b00, 1'b1));
    s.rdy = 1'b0; push(s, memc(1'b1));
    s.rdy = 1'b1; e = memc(1'b1); e.retire = 1'b1; push(s, e);
    // second store: reset lands on a stalled MEM cycle
    push(s, fetch(1'b1)); push(s, dec()); push(s, exu(4'b0010, 2'b00, 1'b1));
    s.rdy = 1'b0; s.rst = 1'b0; push(s, memc(1'b1));
    s.rst = 1'b1; push(s, fetch(1'b0));
    for (int i = 0; i < sq.size(); i++) begin
      apply(sq[i]); #1; total++;
      if (obs !== eq[i]) begin bad++; $display("FAIL store cyc%0d got=%h exp=%h", i, obs, eq[i]); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_jump();
    stim_t s;
    ov_t e;
    do_reset();
    s = mk(OP_JALR, 3'b000, 1'b0, 1'b1);
    push(s, fetch(1'b1)); push(s, dec());
    e = exu(4'b0010, 2'b00, 1'b1); e.pc_we = 1'b1; e.pc_src = 2'b10; push(s, e);
    push(s, wb(2'b10));
    s = mk(OP_JAL, 3'b101, 1'b1, 1'b1);
    push(s, fetch(1'b1)); push(s, dec());
    e = exu(4'b0010, 2'b01, 1'b1); e.pc_we = 1'b1; e.pc_src = 2'b01; push(s, e);
    push(s, wb(2'b10));
    s = mk(OP_LUI, 3'b111, 1'b1, 1'b1);
    push(s, fetch(1'b1)); push(s, dec()); push(s, exu(4'b0010, 2'b10, 1'b1)); push(s, wb(2'b00));
    s = mk(OP_AUIPC, 3'b011, 1'b0, 1'b1);
    push(s, fetch(1'b1)); push(s, dec()); push(s, exu(4'b0010, 2'b01, 1'b1)); push(s, wb(2'b00));
    s.rdy = 1'b0; push(s, fetch(1'b0));
    for (int i = 0; i < sq.size(); i++) begin
      apply(sq[i]); #1; total++;
      if (obs !== eq[i]) begin bad++; $display("FAIL jump cyc%0d got=%h exp=%h", i, obs, eq[i]); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_alu();
    // {is_itype, funct3, funct7_5, aluctl}
    logic [8:0] at [0:14];
    stim_t s;
    at = '{9'b0_000_1_0110, 9'b0_000_0_0010, 9'b0_001_0_0100, 9'b0_010_0_0111, 9'b0_011_0_1001,
           9'b0_100_0_0011, 9'b0_101_0_0101, 9'b0_101_1_1000, 9'b0_110_0_0001, 9'b0_111_0_0000,
           9'b1_000_1_0010, 9'b1_101_1_1000, 9'b1_101_0_0101, 9'b1_100_1_0011, 9'b1_011_0_1001};
    do_reset();
    for (int k = 0; k < 15; k++) begin
      s = mk(at[k][8] ? OP_I : OP_R, at[k][7:5], at[k][4], 1'b1);
      push(s, fetch(1'b1)); push(s, dec()); push(s, exu(at[k][3:0], 2'b00, at[k][8]));
      push(s, wb(2'b00));
    end
    s.rdy = 1'b0; push(s, fetch(1'b0));
    for (int i = 0; i < sq.size(); i++) begin
      apply(sq[i]); #1; total++;
      if (obs !== eq[i]) begin bad++; $display("FAIL alu cyc%0d got=%h exp=%h", i, obs, eq[i]); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_trap();
    stim_t s;
    do_reset();
    s = mk(7'h7F, 3'b000, 1'b0, 1'b1);
    push(s, fetch(1'b1)); push(s, dec());
    for (int k = 0; k < 20; k++) begin
      s.op = k[0] ? OP_R : OP_ST; s.rdy = k[1]; s.z = k[2]; s.lt = k[0];
      push(s, trap());
    end
    s.rst = 1'b0; push(s, trap());
    s.rst = 1'b1; s.rdy = 1'b1;
    s = mk(OP_BR, 3'b010, 1'b0, 1'b1);
    push(s, fetch(1'b1)); push(s, dec()); push(s, trap());
    s.z = 1'b1; push(s, trap());
    s.rst = 1'b0; push(s, trap());
    s.rst = 1'b1; s.rdy = 1'b0; push(s, fetch(1'b0));
    for (int i = 0; i < sq.size(); i++) begin
      apply(sq[i]); #1; total++;
      if (obs !== eq[i]) begin bad++; $display("FAIL trap cyc%0d got=%h exp=%h", i, obs, eq[i]); end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_branch();
    test_load();
    test_store();
    test_jump();
    test_alu();
    test_trap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/multicycle_fsm.md
MULTICYCLE_FSM -- requirements
Module: multicycle_fsm

Interface
REQ-001 The block SHALL have one clock and synchronous active-low reset: clk  in  1  rising-edge clock; rst_n  in  1  reset, sampled on clk, low = reset.
REQ-002 Inputs SHALL be: opcode  in  7  instr[6:0]; funct3  in  3  instr[14:12]; funct7_5  in  1  instr[30]; zero, lt, ltu  in  1 each  ALU flags (rs1==rs2, signed rs1<rs2, unsigned rs1<rs2); mem_ready  in  1  memory access complete.
REQ-003 Outputs SHALL be: pc_we, ir_we, regwrite, mem_req, mem_we, iord  out  1 each; pc_src  out  2  (00 pc+4, 01 ALU target, 10 ALU target & ~1); wb_sel  out  2  (00 ALU, 01 mem data, 10 old_pc+4); alusrc_a  out  2  (00 rs1, 01 old_pc, 10 zero); alusrc_b  out  1  (0 rs2, 1 imm); aluctl  out  4; state  out  3; retire  out  1; illegal  out  1.

Function
REQ-004 States SHALL be FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=7; all outputs are decoded from the registered state and the current opcode/funct/flag inputs (Moore plus decode), with no output registers.
REQ-005 FETCH: mem_req=1, iord=0; while mem_ready=0, stay in FETCH; when mem_ready=1, assert ir_we=1, pc_we=1, pc_src=00 for that cycle and go to DECODE.
REQ-006 DECODE: one cycle, no strobes; supported opcodes 0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111 go to EXEC; any other opcode, or BRANCH with funct3 010/011, goes to TRAP.
REQ-007 EXEC, BRANCH: aluctl=0110, alusrc_a=00, alusrc_b=0; taken = BEQ zero, BNE ~zero, BLT lt, BGE ~lt, BLTU ltu, BGEU ~ltu; if taken, pc_we=1, pc_src=01; retire=1; go to FETCH.
REQ-008 EXEC, JAL: pc_we=1, pc_src=01, alusrc_a=01, alusrc_b=1, aluctl=0010; JALR: the same with alusrc_a=00 and pc_src=10; both go to WB.
REQ-009 EXEC, LOAD/STORE: aluctl=0010, alusrc_a=00, alusrc_b=1; go to MEM.
REQ-010 EXEC, R/I/LUI/AUIPC: go to WB. LUI uses alusrc_a=10, alusrc_b=1. AUIPC uses alusrc_a=01, alusrc_b=1. Both use aluctl=0010.
REQ-011 R-type aluctl by funct3 and funct7_5 SHALL be: ADD 0010, SUB 0110, SLL 0100, SLT 0111, SLTU 1001, XOR 0011, SRL 0101, SRA 1000, OR 0001, AND 0000. I-type SHALL be identical, except funct3=000 is always ADD; funct7_5 selects SRAI only for funct3=101.
REQ-012 MEM: mem_req=1, iord=1, mem_we=1 for STORE and 0 for LOAD; these SHALL be held stable until the cycle mem_ready=1. On that cycle, LOAD goes to WB; STORE asserts retire=1 and goes to FETCH.
REQ-013 WB: regwrite=1 for exactly one cycle; wb_sel=01 for LOAD, 10 for JAL/JALR, 00 otherwise; retire=1; go to FETCH.
REQ-014 TRAP: illegal=1; all strobes SHALL be 0; the FSM stays in TRAP until reset.
REQ-015 Outside the states listed in REQ-005 to REQ-014, every strobe SHALL be 0, and aluctl, alusrc_a/b, pc_src and wb_sel SHALL be 0. Unused state encodings 5 and 6 SHALL go to FETCH on the next edge.
REQ-016 Per-instruction cycle counts, excluding memory wait cycles, SHALL be: BRANCH 3; STORE 4; R/I/LUI/AUIPC/JAL/JALR 4; LOAD 5. Each mem_ready=0 cycle adds 1.

Reset
REQ-017 With rst_n=0 at a rising edge, the next state SHALL be FETCH, and all outputs SHALL be 0 except mem_req=1 (FETCH). Outputs are not gated by rst_n and are decoded from the state.
REQ-018 Reset asserted mid-access (in MEM or WB, or in FETCH with mem_ready=0) SHALL take effect at the next edge. No pc_we, regwrite or mem_we SHALL be issued from the aborted instruction after that edge.
REQ-019 Reset SHALL be the only exit from TRAP.

Verification
REQ-020 ADD x3,x1,x2 (0x002081B3) with mem_ready always 1 -> states FETCH, DECODE, EXEC, WB, FETCH; aluctl=0010 in EXEC; regwrite=1 and wb_sel=00 in WB; retire=1 in WB only.
REQ-021 BNE with zero=1 -> no pc_we in EXEC, retire=1. BNE with zero=0 -> pc_we=1, pc_src=01 in EXEC. Both return to FETCH after 3 cycles.
REQ-022 LW with mem_ready held 0 for 3 cycles in MEM -> mem_req=1, iord=1, mem_we=0 held for 4 cycles; then WB with wb_sel=01; total 8 cycles.
REQ-023 JALR -> EXEC: pc_src=10, alusrc_a=00, pc_we=1; WB: wb_sel=10, regwrite=1.
REQ-024 Opcode 0x7F, and BRANCH with funct3=010 -> TRAP after DECODE with illegal=1. The FSM stays there for 20 cycles with no strobes. rst_n=0 for one edge -> FETCH.
REQ-025 SW with rst_n=0 asserted for the edge ending a MEM cycle in which mem_ready=0 -> next state FETCH, mem_we=0, no retire.
